adc_multi_spi_ctrl: RTL and testbench

//  Parametrised successor to the single-channel MCP3910 readout path: an integrated SPI mode-0 engine
//  and sequencer that reads CH_COUNT ADC channels (DATA_W bits each) per data-ready event.

---
 rtl/adc_ctrl_pkg.sv | 20 ++
 rtl/spi_mode0_shifter.sv | 92 +++++++++
 rtl/adc_multi_spi_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_adc_multi_spi_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared FSM states, command constants and command-byte builder for the multi-channel ADC readout.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP,
    ST_PUBLISH
  } state_e;

  localparam logic READ_BIT = 1'b1;
  localparam int   CMD_W    = 8;

  function automatic logic [CMD_W-1:0] cmd_byte(input logic [1:0] dev, input logic [4:0] addr);
    return {dev, addr, READ_BIT};
  endfunction

endpackage

// File: rtl/spi_mode0_shifter.sv
// SPI mode-0 bit engine: shifts N bits per transfer, samples MISO on SCLK rise and advances MOSI on fall.
// Chip select is owned by the caller; load presets the MOSI word, start begins clocking.
module spi_mode0_shifter #(
  parameter int N       = 32,
  parameter int RX_W    = 24,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [N-1:0]    tx_word,
  input  logic            start,
  input  logic            miso,
  output logic            sclk,
  output logic            mosi,
  output logic            done,
  output logic [RX_W-1:0] rx_word
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(N + 1);

  logic             running_q, running_d;
  logic             sclk_q, sclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N-1:0]     tx_q, tx_d;
  logic [RX_W-1:0]  rx_q, rx_d;
  logic             half_end;

  assign half_end = running_q && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    running_d = running_q;
    sclk_d    = sclk_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done      = 1'b0;
    if (load) begin
      tx_d = tx_word;
    end
    if (start) begin
      running_d = 1'b1;
      sclk_d    = 1'b0;
      cnt_d     = '0;
      bit_d     = '0;
    end else if (running_q) begin
      if (half_end) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[RX_W-2:0], miso};
        end else begin
          // Falling edge closes a bit period; zeros shift in so MOSI idles low afterwards.
          tx_d  = {tx_q[N-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(N - 1)) begin
            running_d = 1'b0;
            done      = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      sclk_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      running_q <= running_d;
      sclk_q    <= sclk_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = tx_q[N-1];
  assign rx_word = rx_q;

endmodule

// File: rtl/adc_multi_spi_ctrl.sv
// Sequencer reading CH_COUNT ADC channels per data-ready edge and publishing them atomically.
// Optional ADC_AVG_EN: averages 2^AVG_LOG2 sweeps per channel before publishing.
module adc_multi_spi_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int         CH_COUNT     = 2,
  parameter int         DATA_W       = 24,
  parameter int         CLK_DIV      = 4,
  parameter logic [1:0] DEV_ADDR     = 2'b01,
  parameter logic [4:0] CH_BASE_ADDR = 5'h00,
  parameter int         AVG_LOG2     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         dr_n,
  input  logic                         clr_overrun,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso,
  output logic                         cs_n,
  output logic [CH_COUNT*DATA_W-1:0]   data_o,
  output logic                         frame_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int N     = CMD_W + DATA_W;
  localparam int CH_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              dr_meta_q, dr_sync_q, dr_prev_q;
  logic              dr_fall, cnt_done;
  logic              load, start, capture, sweep_end, publish, pub_ok;
  logic              sh_done;
  logic [N-1:0]      tx_word;
  logic [DATA_W-1:0] sample;

  assign dr_fall  = dr_prev_q & ~dr_sync_q;
  assign cnt_done = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    start     = 1'b0;
    capture   = 1'b0;
    sweep_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dr_fall && enable) begin
          state_d = ST_CS_SETUP;
          ch_d    = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          start   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          state_d = ST_CS_HOLD;
          capture = 1'b1;
        end
      end
      ST_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          cnt_d = '0;
          if (ch_q == CH_W'(CH_COUNT - 1)) begin
            sweep_end = 1'b1;
            state_d   = pub_ok ? ST_PUBLISH : ST_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            load    = 1'b1;
            state_d = ST_CS_SETUP;
          end
        end
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Command is built from ch_d because it is loaded on the edge entering CS_SETUP.
  assign tx_word = {cmd_byte(DEV_ADDR, CH_BASE_ADDR + 5'(ch_d)), {DATA_W{1'b0}}};
  assign publish = sweep_end & pub_ok;

  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (dr_fall && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      dr_meta_q <= 1'b1;
      dr_sync_q <= 1'b1;
      dr_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      dr_meta_q <= dr_n;
      dr_sync_q <= dr_meta_q;
      dr_prev_q <= dr_sync_q;
    end
  end

`ifdef ADC_AVG_EN
  localparam int SW_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  logic [SW_W-1:0] sweep_cnt_q, sweep_cnt_d;

  assign pub_ok = (AVG_LOG2 == 0) || (sweep_cnt_q == SW_W'((1 << AVG_LOG2) - 1));

  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    if (sweep_end) sweep_cnt_d = pub_ok ? '0 : sweep_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_cnt_q <= '0;
    else        sweep_cnt_q <= sweep_cnt_d;
  end
`else
  assign pub_ok = 1'b1;
`endif

  spi_mode0_shifter #(
    .N       (N),
    .RX_W    (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tx_word (tx_word),
    .start   (start),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (sh_done),
    .rx_word (sample)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CH_COUNT; gi++) begin : g_ch
      logic [DATA_W-1:0] data_q, data_d;
      logic [DATA_W-1:0] pub_value;
      logic              hit;

      assign hit = capture && (ch_q == CH_W'(gi));

`ifdef ADC_AVG_EN
      localparam int ACC_W = DATA_W + AVG_LOG2;
      logic signed [ACC_W-1:0] acc_q, acc_d;

      always_comb begin
        acc_d = acc_q;
        if (hit)     acc_d = acc_q + ACC_W'($signed(sample));
        if (publish) acc_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
      end

      // Arithmetic shift floors toward -inf, matching the ADC's two's-complement range.
      assign pub_value = DATA_W'(acc_q >>> AVG_LOG2);
`else
      logic [DATA_W-1:0] shadow_q, shadow_d;

      assign shadow_d = hit ? sample : shadow_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
      end

      assign pub_value = shadow_q;
`endif

      assign data_d = publish ? pub_value : data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
      end

      assign data_o[gi*DATA_W +: DATA_W] = data_q;
    end
  endgenerate

  assign cs_n        = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_CS_HOLD));
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_PUBLISH);
  assign frame_valid = (state_q == ST_PUBLISH);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_multi_spi_ctrl.sv
// Scoreboard bench for adc_multi_spi_ctrl: behavioural ADC slaves, stimulus pushes expected frames.
// Works with or without ADC_AVG_EN defined.
module tb_adc_multi_spi_ctrl;

  localparam int CH = 2;
  localparam int DW = 24;
  localparam int CD = 2;
  localparam int NB = 8 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic dr_n = 1'b1;
  logic dr_n_b = 1'b1;
  logic clr_overrun = 1'b0;
  logic miso_a = 1'b0;
  logic miso_b = 1'b0;

  logic          sclk_a, mosi_a, cs_n_a, fv_a, busy_a, ovr_a;
  logic [CH*DW-1:0] data_a;
  logic          sclk_b, mosi_b, cs_n_b, fv_b, busy_b, ovr_b;
  logic [15:0]   data_b;

  adc_multi_spi_ctrl #(
    .CH_COUNT(CH), .DATA_W(DW), .CLK_DIV(CD), .DEV_ADDR(2'b01), .CH_BASE_ADDR(5'h00), .AVG_LOG2(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dr_n(dr_n), .clr_overrun(clr_overrun),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a),
    .data_o(data_a), .frame_valid(fv_a), .busy(busy_a), .overrun(ovr_a)
  );

  adc_multi_spi_ctrl #(
    .CH_COUNT(1), .DATA_W(16), .CLK_DIV(1), .DEV_ADDR(2'b01), .CH_BASE_ADDR(5'h00), .AVG_LOG2(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dr_n(dr_n_b), .clr_overrun(clr_overrun),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b),
    .data_o(data_b), .frame_valid(fv_b), .busy(busy_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- expected-frame model + scoreboard ----------------
  logic [CH*DW-1:0] exp_q[$];
`ifdef ADC_AVG_EN
  logic signed [DW+1:0] m_acc0, m_acc1;
  int m_n = 0;
`endif

  task automatic model_reset();
`ifdef ADC_AVG_EN
    m_acc0 = '0;
    m_acc1 = '0;
    m_n    = 0;
`endif
  endtask

  task automatic model_push(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
`ifdef ADC_AVG_EN
    logic signed [DW+1:0] s0, s1;
    m_acc0 = m_acc0 + $signed({{2{d0[DW-1]}}, d0});
    m_acc1 = m_acc1 + $signed({{2{d1[DW-1]}}, d1});
    m_n++;
    if (m_n == 4) begin
      s0 = m_acc0 >>> 2;
      s1 = m_acc1 >>> 2;
      exp_q.push_back({s1[DW-1:0], s0[DW-1:0]});
      model_reset();
    end
`else
    exp_q.push_back({d1, d0});
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && fv_a) begin
      if (exp_q.size() == 0) begin
        check("frame_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [CH*DW-1:0] e;
        e = exp_q.pop_front();
        $display("frame_valid: data_o=%h expected=%h", data_a, e);
        check("data_o", 64'(data_a), 64'(e));
        check("busy_at_publish", 64'(busy_a), 64'd0);
      end
    end
  end

  // ---------------- ADC slave model, instance A ----------------
  logic [DW-1:0] tbl0 = '0, tbl1 = '0;
  logic          cs_pa = 1'b1, sclk_pa = 1'b0;
  int            bit_a = 0, frame_idx = 0, low_a = 0;
  logic [7:0]    cmd_a = '0;
  logic [NB-1:0] word_a = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bit_a = 0; frame_idx = 0; low_a = 0; cs_pa = 1'b1; sclk_pa = 1'b0; miso_a = 1'b0;
    end else begin
      if (!cs_n_a) low_a++;
      if (cs_pa && !cs_n_a) begin
        bit_a  = 0;
        word_a = {8'h00, (frame_idx % CH == 1) ? tbl1 : tbl0};
        miso_a = word_a[NB-1];
      end
      if (!cs_n_a && !sclk_pa && sclk_a) begin
        cmd_a = {cmd_a[6:0], mosi_a};
        bit_a++;
        if (bit_a == 8) check("cmd_byte", 64'(cmd_a), 64'({2'b01, 5'(frame_idx % CH), 1'b1}));
      end
      if (!cs_n_a && sclk_pa && !sclk_a && bit_a < NB) miso_a = word_a[NB-1-bit_a];
      if (!cs_pa && cs_n_a) begin
        $display("spi frame %0d: cmd=%h cs_low=%0d rises=%0d", frame_idx, cmd_a, low_a, bit_a);
        check("cs_low_cycles", 64'(low_a), 64'(CD * (2 * NB + 2)));
        check("sclk_rises", 64'(bit_a), 64'(NB));
        frame_idx++;
        low_a = 0;
      end
      cs_pa   = cs_n_a;
      sclk_pa = sclk_a;
    end
  end

  // ---------------- ADC slave model, instance B (16-bit, CLK_DIV=1) ----------------
  logic        cs_pb = 1'b1, sclk_pb = 1'b0;
  int          bit_b = 0, nfv_b = 0;
  logic [23:0] word_b = 24'h008000;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cs_pb && !cs_n_b) begin bit_b = 0; miso_b = word_b[23]; end
      if (!cs_n_b && !sclk_pb && sclk_b) bit_b++;
      if (!cs_n_b && sclk_pb && !sclk_b && bit_b < 24) miso_b = word_b[23-bit_b];
      if (!cs_pb && cs_n_b) check("b_sclk_rises", 64'(bit_b), 64'd24);
      if (fv_b) begin
        nfv_b++;
        $display("dut_b frame_valid: data_o=%h", data_b);
        check("b_data_o", 64'(data_b), 64'h8000);
      end
      cs_pb   = cs_n_b;
      sclk_pb = sclk_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget && busy_a !== lvl; i++) @(negedge clk);
    check(name, 64'(busy_a), 64'(lvl));
  endtask

  task automatic start_sweep(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit push);
    tbl0 = d0;
    tbl1 = d1;
    if (push) model_push(d0, d1);
    dr_n = 1'b0;
    wait_busy(1'b1, 20, "busy_rise");
  endtask

  task automatic finish_sweep();
    wait_busy(1'b0, 3000, "busy_fall");
    dr_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int seen;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(cs_n_a), 64'd1);
    check("rst_sclk", 64'(sclk_a), 64'd0);
    check("rst_mosi", 64'(mosi_a), 64'd0);
    check("rst_data_o", 64'(data_a), 64'd0);
    check("rst_frame_valid", 64'(fv_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_overrun", 64'(ovr_a), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Basic two-channel sweep
    start_sweep(24'h123456, 24'hFEDCBA, 1'b1);
    finish_sweep();
    check("overrun_idle", 64'(ovr_a), 64'd0);

    // Overrun: second data-ready edge while busy
    start_sweep(24'h000777, 24'h7FFFFF, 1'b1);
    repeat (60) @(negedge clk);
    dr_n = 1'b1;
    repeat (4) @(negedge clk);
    dr_n = 1'b0;
    repeat (4) @(negedge clk);
    check("overrun_set", 64'(ovr_a), 64'd1);
    finish_sweep();
    check("overrun_sticky", 64'(ovr_a), 64'd1);
    check("no_extra_sweep", 64'(busy_a), 64'd0);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_cleared", 64'(ovr_a), 64'd0);

    // Enable drops during channel 0: sweep still completes, then no new sweeps
    start_sweep(24'h800000, 24'h000001, 1'b1);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    finish_sweep();
    dr_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) seen++;
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) seen++;
    end
    check("no_sweep_when_disabled_or_held", 64'(seen), 64'd0);
    dr_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-SHIFT aborts at once
    start_sweep(24'hAAAAAA, 24'h555555, 1'b0);
    for (int i = 0; i < 200 && sclk_a !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 64'(cs_n_a), 64'd1);
    check("abort_sclk", 64'(sclk_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_data_o", 64'(data_a), 64'd0);
    model_reset();
    dr_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Four sweeps of negative/positive samples (averaged when enabled)
    start_sweep(24'hFFFFFC, 24'd10, 1'b1); finish_sweep();
    start_sweep(24'hFFFFFD, 24'd11, 1'b1); finish_sweep();
    start_sweep(24'hFFFFFE, 24'd12, 1'b1); finish_sweep();
    start_sweep(24'hFFFFFE, 24'd13, 1'b1); finish_sweep();

    // 16-bit instance, CLK_DIV=1, 0x8000 on MISO
    for (int s = 0; s < 4; s++) begin
      dr_n_b = 1'b0;
      for (int i = 0; i < 20 && busy_b !== 1'b1; i++) @(negedge clk);
      for (int i = 0; i < 300 && busy_b !== 1'b0; i++) @(negedge clk);
      check("b_busy_fall", 64'(busy_b), 64'd0);
      dr_n_b = 1'b1;
      repeat (6) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef ADC_AVG_EN
    check("b_frame_count", 64'(nfv_b), 64'd1);
`else
    check("b_frame_count", 64'(nfv_b), 64'd4);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
